// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock over WIDTH+1
// extended bits, signed or unsigned, behind a start/busy/done handshake.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_md,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p_full,
  output logic [WIDTH-1:0]   p,
  output logic               ovf
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     acc_a_q, acc_a_d;     // A: upper accumulator half
  logic [WIDTH:0]     acc_q_q, acc_q_d;     // Q: multiplier / lower half
  logic               q_m1_q, q_m1_d;       // q_1: Booth look-behind bit
  logic [WIDTH:0]     mcand_q, mcand_d;     // ext(a), frozen for the operation
  logic               sm_q, sm_d;           // mode captured with start
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_full_q, p_full_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     a_ext, b_ext, sum, step_a, step_q;
  logic               step_q1;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic               prod_ovf;
  logic               load;

  // Booth step datapath: conditional add/subtract, then arithmetic shift.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sum     = acc_a_q;
    a_ext   = signed_md ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext   = signed_md ? {b[WIDTH-1], b} : {1'b0, b};
    case ({acc_q_q[0], q_m1_q})
      2'b01:   sum = acc_a_q + mcand_q;
      2'b10:   sum = acc_a_q - mcand_q;
      default: sum = acc_a_q;
    endcase
    step_a  = {sum[WIDTH], sum[WIDTH:1]};
    step_q  = {sum[0], acc_q_q[WIDTH:1]};
    step_q1 = acc_q_q[0];
    // After WIDTH+1 steps {A,Q} holds the exact product of the extended
    // operands; it always fits in 2*WIDTH bits, so the low half is taken.
    prod     = {step_a[WIDTH-2:0], step_q};
    prod_top = prod[2*WIDTH-1:WIDTH-1];
    prod_ovf = sm_q ? !((&prod_top) || (~|prod_top))
                    : (|prod[2*WIDTH-1:WIDTH]);
  end

  // Control FSM: next state, operand load, step iteration and result capture.
  always_comb begin
    state_d  = state_q;
    acc_a_d  = acc_a_q;
    acc_q_d  = acc_q_q;
    q_m1_d   = q_m1_q;
    mcand_d  = mcand_q;
    sm_d     = sm_q;
    cnt_d    = cnt_q;
    p_full_d = p_full_q;
    ovf_d    = ovf_q;
    load     = start && (state_q != S_RUN);

    case (state_q)
      S_RUN: begin
        acc_a_d = step_a;
        acc_q_d = step_q;
        q_m1_d  = step_q1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d  = S_DONE;
          p_full_d = prod;
          ovf_d    = prod_ovf;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_RUN;
      acc_a_d = '0;
      acc_q_d = b_ext;
      q_m1_d  = 1'b0;
      mcand_d = a_ext;
      sm_d    = signed_md;
      cnt_d   = '0;
    end
  end

  // State and datapath registers; reset clears every one of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_a_q  <= '0;
      acc_q_q  <= '0;
      q_m1_q   <= 1'b0;
      mcand_q  <= '0;
      sm_q     <= 1'b0;
      cnt_q    <= '0;
      p_full_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      acc_a_q  <= acc_a_d;
      acc_q_q  <= acc_q_d;
      q_m1_q   <= q_m1_d;
      mcand_q  <= mcand_d;
      sm_q     <= sm_d;
      cnt_q    <= cnt_d;
      p_full_q <= p_full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign p_full = p_full_q;
  assign p      = p_full_q[WIDTH-1:0];
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed cases at WIDTH=8 and
// randomized operands at WIDTH=16 against a plain-arithmetic reference.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, ovf8;
  logic [15:0] pf8;
  logic [7:0]  p8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, ovf16;
  logic [31:0] pf16;
  logic [15:0] p16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_md(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .p_full(pf8), .p(p8), .ovf(ovf8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_md(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16),
    .p_full(pf16), .p(p16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the operands read in the chosen mode.
  function automatic longint ref_prod(input logic sm, input logic [15:0] av,
                                      input logic [15:0] bv);
    longint x, y;
    x = sm ? longint'($signed(av)) : longint'(av);
    y = sm ? longint'($signed(bv)) : longint'(bv);
    return x * y;
  endfunction

  function automatic logic ref_ovf16(input logic sm, input longint prod);
    if (sm) return (prod < -32768) || (prod > 32767);
    return prod > 65535;
  endfunction

  // Called at a negedge: presents a one-cycle start pulse, returns at next negedge.
  task automatic pulse8(input logic sm, input logic [7:0] av, input logic [7:0] bv);
    sm8 = sm; a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts negedges since the start edge until done (bounded).
  task automatic wait_done8(output int lat, output int bc, output int both);
    lat = 1; bc = busy8 ? 1 : 0; both = (busy8 && done8) ? 1 : 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy8) bc++;
      if (busy8 && done8) both++;
    end
  endtask

  initial begin
    int lat, bc, both, cnt;
    longint rp;
    logic [31:0] exp_pf;

    // Reset state
    @(negedge clk);
    check("rst_busy8",  busy8, 0);
    check("rst_done8",  done8, 0);
    check("rst_pf8",    pf8,   0);
    check("rst_ovf8",   ovf8,  0);
    check("rst_pf16",   pf16,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 7 * -3 signed, with exact latency and busy length
    pulse8(1'b1, 8'h07, 8'hFD);
    check("busy_after_start", busy8, 1);
    wait_done8(lat, bc, both);
    check("m73_done",    done8, 1);
    check("m73_latency", lat, 10);
    check("m73_busylen", bc, 9);
    check("m73_overlap", both, 0);
    check("m73_pfull",   pf8, 16'hFFEB);
    check("m73_p",       p8,  8'hEB);
    check("m73_ovf",     ovf8, 0);
    @(negedge clk);
    check("m73_done_pulse", done8, 0);
    check("m73_idle_busy",  busy8, 0);
    repeat (3) @(negedge clk);
    check("m73_held", pf8, 16'hFFEB);

    // Most-negative signed corner
    pulse8(1'b1, 8'h80, 8'h80);
    wait_done8(lat, bc, both);
    check("mneg_pfull", pf8, 16'h4000);
    check("mneg_ovf",   ovf8, 1);
    @(negedge clk);

    // Unsigned max
    pulse8(1'b0, 8'hFF, 8'hFF);
    wait_done8(lat, bc, both);
    check("umax_pfull", pf8, 16'hFE01);
    check("umax_ovf",   ovf8, 1);
    @(negedge clk);

    // Unsigned, fits
    pulse8(1'b0, 8'h0F, 8'h11);
    wait_done8(lat, bc, both);
    check("u0f11_pfull", pf8, 16'h00FF);
    check("u0f11_ovf",   ovf8, 0);
    @(negedge clk);

    // Start during RUN is ignored; operand inputs change freely
    pulse8(1'b1, 8'h05, 8'h06);
    repeat (2) @(negedge clk);
    sm8 = 1'b0; a8 = 8'hF1; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(lat, bc, both);
    check("ign_done",  done8, 1);
    check("ign_pfull", pf8, 16'h001E);
    check("ign_ovf",   ovf8, 0);
    @(negedge clk);
    check("ign_no_second", busy8, 0);

    // Reset during RUN step 4: outputs clear at once, no done afterwards
    pulse8(1'b0, 8'hC3, 8'h5A);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy8, 0);
    check("mrst_done", done8, 0);
    check("mrst_pf",   pf8, 0);
    check("mrst_p",    p8, 0);
    check("mrst_ovf",  ovf8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8 || busy8) cnt++;
    end
    check("mrst_no_done", cnt, 0);

    // Back-to-back: start held high through DONE
    sm8 = 1'b1; a8 = 8'h7F; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    wait_done8(lat, bc, both);
    check("b2b_first_lat",   lat, 10);
    check("b2b_first_pfull", pf8, 16'h00FE);
    check("b2b_first_ovf",   ovf8, 1);
    sm8 = 1'b0; a8 = 8'h10; b8 = 8'h0A;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_second_busy", busy8, 1);
    wait_done8(lat, bc, both);
    check("b2b_gap",          lat, 10);
    check("b2b_second_pfull", pf8, 16'h00A0);
    check("b2b_second_ovf",   ovf8, 0);
    @(negedge clk);

    // WIDTH=16 randomized against the reference model
    for (int n = 0; n < 2000; n++) begin
      logic sm;
      logic [15:0] av, bv;
      sm = 1'($urandom_range(0, 1));
      av = 16'($urandom);
      bv = 16'($urandom);
      if (n == 0) begin sm = 1'b1; av = 16'h8000; bv = 16'h8000; end
      if (n == 1) begin sm = 1'b0; av = 16'hFFFF; bv = 16'hFFFF; end
      if (n == 2) begin sm = 1'b1; av = 16'hFFFF; bv = 16'h8000; end
      rp     = ref_prod(sm, av, bv);
      exp_pf = rp[31:0];
      sm16 = sm; a16 = av; b16 = bv; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      cnt = 1;
      while (!done16 && cnt < 60) begin
        @(negedge clk);
        cnt++;
      end
      check("w16_done",  done16, 1);
      check("w16_pfull", pf16, exp_pf);
      check("w16_ovf",   ovf16, ref_ovf16(sm, rp));
      if (done16 !== 1'b1) break;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
